// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage.
//   - Bit positions of the one-hot instruction decode bus (width IB_W).
//   - Reset PC of the writeback stage and default data-memory depth.
package mem_stage_pkg;

  localparam int IB_W = 28;

  // One-hot decode bus bit indices (bit 27 down to bit 0).
  localparam int CAL_R = 27;
  localparam int CAL_I = 26;
  localparam int CAL_L = 25;
  localparam int CAL_S = 24;
  localparam int CAL_B = 23;
  localparam int CAL_M = 22;
  localparam int ADDU  = 21;
  localparam int SUBU  = 20;
  localparam int ORI   = 19;
  localparam int LW    = 18;
  localparam int SW    = 17;
  localparam int BEQ   = 16;
  localparam int LUI   = 15;
  localparam int J     = 14;
  localparam int JAL   = 13;
  localparam int JR    = 12;
  localparam int NOP   = 11;
  localparam int YNEW  = 10;
  localparam int ADD   = 9;
  localparam int SUB   = 8;
  localparam int ANDX  = 7;
  localparam int ORX   = 6;
  localparam int XORX  = 5;
  localparam int NORX  = 4;
  localparam int ADDI  = 3;
  localparam int ADDIU = 2;
  localparam int ANDI  = 1;
  localparam int XORI  = 0;

  localparam logic [31:0] PC_RESET_VAL     = 32'h0000_3000;
  localparam int          DM_WORDS_DEFAULT = 1024;

endpackage

// File: rtl/mem_stage_dm_ram.sv
// dm_ram: word-organised data memory of the memory stage.
//   clk    in   pipeline clock
//   reset  in   asynchronous active-high reset, clears every word
//   we     in   write request (already qualified as a store)
//   idx    in   full 30-bit word address (byte address >> 2)
//   wdata  in   store data
//   rdata  out  combinational read data, 0 when idx is past the end
// The full word address is taken so the range check lives here: writes
// and reads beyond WORDS are dropped / read as zero instead of aliasing.
module dm_ram #(
  parameter int WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [29:0] idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);

  localparam int AW = $clog2(WORDS);

  logic [31:0]   mem_q [WORDS];
  logic          in_range;
  logic [AW-1:0] widx;

  assign in_range = (idx < 30'(WORDS));
  assign widx     = idx[AW-1:0];

  // Whole-array clear on reset is required, so this is a register file
  // rather than a block RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else if (we && in_range) begin
      mem_q[widx] <= wdata;
    end
  end

  assign rdata = in_range ? mem_q[widx] : 32'h0;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory (M) stage of the 5-stage MIPS pipeline.
//   clk, reset     pipeline clock, asynchronous active-high reset
//   M_vin          value from E (ALU result / store data / lui imm / pc+8)
//   M_a1/M_a2/M_a3 rs, rt (store-data source) and destination addresses
//   M_grf_en       instruction writes the register file
//   M_dm_en        instruction writes data memory
//   M_pc           instruction PC
//   M_instrbus     one-hot decode bus (see mem_stage_pkg)
//   M_aluo         ALU output, byte address for lw/sw
//   M_fwd          combinational bypass value (= M_vin) for upstream use
//   W_*            M/W pipeline register outputs
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int          DM_WORDS = DM_WORDS_DEFAULT,
  parameter logic [31:0] PC_RESET = PC_RESET_VAL
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     M_vin,
  input  logic [4:0]      M_a1,
  input  logic [4:0]      M_a2,
  input  logic [4:0]      M_a3,
  input  logic            M_grf_en,
  input  logic            M_dm_en,
  input  logic [31:0]     M_pc,
  input  logic [IB_W-1:0] M_instrbus,
  input  logic [31:0]     M_aluo,
  output logic [31:0]     M_fwd,
  output logic [4:0]      W_a3,
  output logic            W_grf_en,
  output logic [31:0]     W_pc,
  output logic [IB_W-1:0] W_instrbus,
  output logic [31:0]     W_wd
);

  logic [4:0]      w_a3_q, w_a3_d;
  logic            w_grf_en_q, w_grf_en_d;
  logic [31:0]     w_pc_q, w_pc_d;
  logic [IB_W-1:0] w_instrbus_q, w_instrbus_d;
  logic [31:0]     w_wd_q, w_wd_d;

  logic [31:0] sdata;
  logic [31:0] rdata;
  logic        dm_we;

  // rs is not consumed here; byte offset bits are ignored (word aligned).
  logic unused_sig;
  assign unused_sig = ^{M_a1, M_aluo[1:0]};

  assign M_fwd = M_vin;

  // The instruction now in W has not written the GRF yet, so a store
  // reading the same rt must take the W value. $0 is never forwarded.
  always_comb begin
    sdata = M_vin;
    if (w_grf_en_q && (w_a3_q != 5'd0) && (w_a3_q == M_a2)) begin
      sdata = w_wd_q;
    end
  end

  assign dm_we = M_dm_en && M_instrbus[SW];

  dm_ram #(
    .WORDS (DM_WORDS)
  ) u_dm (
    .clk   (clk),
    .reset (reset),
    .we    (dm_we),
    .idx   (M_aluo[31:2]),
    .wdata (sdata),
    .rdata (rdata)
  );

  always_comb begin
    w_a3_d       = M_a3;
    w_grf_en_d   = M_grf_en;
    w_pc_d       = M_pc;
    w_instrbus_d = M_instrbus;
    w_wd_d       = M_vin;
    if (M_instrbus[CAL_L] || M_instrbus[LW]) begin
      w_wd_d = rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_a3_q       <= 5'd0;
      w_grf_en_q   <= 1'b0;
      w_pc_q       <= PC_RESET;
      w_instrbus_q <= '0;
      w_wd_q       <= 32'h0;
    end else begin
      w_a3_q       <= w_a3_d;
      w_grf_en_q   <= w_grf_en_d;
      w_pc_q       <= w_pc_d;
      w_instrbus_q <= w_instrbus_d;
      w_wd_q       <= w_wd_d;
    end
  end

  assign W_a3       = w_a3_q;
  assign W_grf_en   = w_grf_en_q;
  assign W_pc       = w_pc_q;
  assign W_instrbus = w_instrbus_q;
  assign W_wd       = w_wd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// traffic, all compared against a word-array reference model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int DMW = 1024;

  localparam logic [27:0] IB_ADDU = (28'd1 << CAL_R) | (28'd1 << ADDU);
  localparam logic [27:0] IB_LW   = (28'd1 << CAL_L) | (28'd1 << LW);
  localparam logic [27:0] IB_SW   = (28'd1 << CAL_S) | (28'd1 << SW);
  localparam logic [27:0] IB_JAL  = (28'd1 << JAL);

  logic        clk;
  logic        reset;
  logic [31:0] M_vin;
  logic [4:0]  M_a1, M_a2, M_a3;
  logic        M_grf_en, M_dm_en;
  logic [31:0] M_pc;
  logic [27:0] M_instrbus;
  logic [31:0] M_aluo;
  logic [31:0] M_fwd;
  logic [4:0]  W_a3;
  logic        W_grf_en;
  logic [31:0] W_pc;
  logic [27:0] W_instrbus;
  logic [31:0] W_wd;

  mem_stage #(.DM_WORDS(DMW), .PC_RESET(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .M_vin      (M_vin),
    .M_a1       (M_a1),
    .M_a2       (M_a2),
    .M_a3       (M_a3),
    .M_grf_en   (M_grf_en),
    .M_dm_en    (M_dm_en),
    .M_pc       (M_pc),
    .M_instrbus (M_instrbus),
    .M_aluo     (M_aluo),
    .M_fwd      (M_fwd),
    .W_a3       (W_a3),
    .W_grf_en   (W_grf_en),
    .W_pc       (W_pc),
    .W_instrbus (W_instrbus),
    .W_wd       (W_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: data memory as a plain array plus expected W fields.
  logic [31:0] ref_mem [DMW];
  logic [4:0]  exp_a3;
  logic        exp_grf;
  logic [31:0] exp_pc;
  logic [27:0] exp_ib;
  logic [31:0] exp_wd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DMW; i++) ref_mem[i] = 32'h0;
    exp_a3  = 5'd0;
    exp_grf = 1'b0;
    exp_pc  = 32'h0000_3000;
    exp_ib  = 28'h0;
    exp_wd  = 32'h0;
  endtask

  task automatic check_w(input string tag);
    check({tag, ".W_wd"},       W_wd,       exp_wd);
    check({tag, ".W_a3"},       32'(W_a3),  32'(exp_a3));
    check({tag, ".W_grf_en"},   32'(W_grf_en), 32'(exp_grf));
    check({tag, ".W_pc"},       W_pc,       exp_pc);
    check({tag, ".W_instrbus"}, 32'(W_instrbus), 32'(exp_ib));
  endtask

  // One instruction through M: drive, check bypass, advance a clock, check W.
  task automatic step(input string tag, input logic [27:0] ib, input logic [4:0] a2,
                      input logic [4:0] a3, input logic ge, input logic de,
                      input logic [31:0] vin, input logic [31:0] aluo, input logic [31:0] pc);
    logic [31:0] word;
    logic        inr;
    logic [31:0] rd;
    logic [31:0] sd;
    logic        is_load;
    M_instrbus = ib; M_a1 = 5'd0; M_a2 = a2; M_a3 = a3;
    M_grf_en = ge; M_dm_en = de; M_vin = vin; M_aluo = aluo; M_pc = pc;
    #1;
    check({tag, ".M_fwd"}, M_fwd, vin);
    word    = aluo / 4;
    inr     = (word < DMW);
    rd      = inr ? ref_mem[word] : 32'h0;
    sd      = (exp_grf && exp_a3 != 0 && exp_a3 == a2) ? exp_wd : vin;
    is_load = ib[CAL_L] | ib[LW];
    if (de && ib[SW] && inr) ref_mem[word] = sd;
    exp_a3  = a3;
    exp_grf = ge;
    exp_pc  = pc;
    exp_ib  = ib;
    exp_wd  = is_load ? rd : vin;
    @(posedge clk);
    #1;
    check_w(tag);
  endtask

  task automatic bubble(input string tag);
    step(tag, 28'h0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic lw(input string tag, input logic [31:0] addr, input logic [4:0] a3);
    step(tag, IB_LW, 5'd0, a3, 1'b1, 1'b0, 32'h0, addr, 32'h3100);
  endtask

  task automatic sw(input string tag, input logic [31:0] addr, input logic [4:0] a2,
                    input logic [31:0] vin);
    step(tag, IB_SW, a2, 5'd0, 1'b0, 1'b1, vin, addr, 32'h3200);
  endtask

  initial begin
    logic [31:0] raddr;
    logic [31:0] rvin;
    int          kind;

    reset = 1'b1;
    M_vin = 0; M_a1 = 0; M_a2 = 0; M_a3 = 0; M_grf_en = 0; M_dm_en = 0;
    M_pc = 0; M_instrbus = 0; M_aluo = 0;
    model_reset();
    #3;
    check_w("reset");
    #9;
    reset = 1'b0;

    // Store then load of the same word.
    sw("sw10", 32'h10, 5'd9, 32'h1234_5678);
    lw("lw10", 32'h10, 5'd4);

    // W-to-M forwarding of store data, and $0 never forwarded.
    step("addu8", IB_ADDU, 5'd1, 5'd8, 1'b1, 1'b0, 32'hCAFE_0001, 32'h0, 32'h3004);
    sw("sw20fwd", 32'h20, 5'd8, 32'h0);
    lw("lw20", 32'h20, 5'd5);
    step("addu0", IB_ADDU, 5'd1, 5'd0, 1'b1, 1'b0, 32'hBAD0_BAD0, 32'h0, 32'h3008);
    sw("sw24zero", 32'h24, 5'd0, 32'h0);
    lw("lw24", 32'h24, 5'd5);
    step("addu8b", IB_ADDU, 5'd1, 5'd8, 1'b1, 1'b0, 32'h5555_AAAA, 32'h0, 32'h300C);
    sw("sw28a2z", 32'h28, 5'd0, 32'h0000_0077);
    lw("lw28", 32'h28, 5'd5);

    // Unaligned address and out-of-range store/load.
    sw("sw13", 32'h13, 5'd2, 32'hA5A5_0013);
    lw("lw10b", 32'h10, 5'd6);
    sw("swoor", DMW * 4, 5'd2, 32'hFFFF_FFFF);
    lw("lwoor", DMW * 4, 5'd6);
    lw("lw0", 32'h0, 5'd6);
    lw("lwlast", (DMW - 1) * 4, 5'd6);

    // Non-memory pass-through, including a stray dm_en on addu.
    step("addu3", IB_ADDU, 5'd0, 5'd3, 1'b1, 1'b0, 32'h7, 32'h7, 32'h3008);
    step("jal", IB_JAL, 5'd0, 5'd31, 1'b1, 1'b0, 32'h3010, 32'h0, 32'h3008);
    step("addude", IB_ADDU, 5'd0, 5'd3, 1'b1, 1'b1, 32'h0000_0099, 32'h30, 32'h300C);
    lw("lw30", 32'h30, 5'd7);

    // Bubbles leave memory untouched.
    bubble("bub0");
    bubble("bub1");
    bubble("bub2");
    lw("lw10c", 32'h10, 5'd7);
    lw("lw20b", 32'h20, 5'd7);
    lw("lw0b", 32'h0, 5'd7);

    // Asynchronous reset between edges, after a store to word 0.
    sw("swdead", 32'h0, 5'd0, 32'hDEAD_BEEF);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_w("asyncrst");
    #2;
    reset = 1'b0;
    lw("lw0rst", 32'h0, 5'd2);
    lw("lw10rst", 32'h10, 5'd2);

    // Random traffic concentrated on a few words and registers.
    for (int i = 0; i < 300; i++) begin
      kind  = $urandom_range(0, 4);
      raddr = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, DMW + 3))
                                          : 32'($urandom_range(0, 15));
      raddr = (raddr << 2) | 32'($urandom_range(0, 3));
      rvin  = $urandom;
      case (kind)
        0: step("r_addu", IB_ADDU, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), rvin, raddr,
                32'h3000 + 32'(i * 4));
        1: step("r_lw", IB_LW, 5'd0, 5'($urandom_range(0, 3)), 1'b1, 1'b0, rvin, raddr,
                32'h3000 + 32'(i * 4));
        2: step("r_sw", IB_SW, 5'($urandom_range(0, 3)), 5'd0, 1'b0, 1'b1, rvin, raddr,
                32'h3000 + 32'(i * 4));
        3: step("r_jal", IB_JAL, 5'd0, 5'd31, 1'b1, 1'b0, rvin, raddr,
                32'h3000 + 32'(i * 4));
        default: bubble("r_bub");
      endcase
    end

    // Sweep back over the hot words.
    for (int w = 0; w < 16; w++) lw("sweep", 32'(w * 4), 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory (M) stage of the 5-stage MIPS pipeline.
- Consumes the E/M pipeline registers produced by the execute stage (ALU result, store/result value, register addresses, instruction bus).
- Owns the word-addressed data memory, performs lw/sw, and registers everything the writeback stage needs into the M/W pipeline register.
- Forwards the writeback-stage value back onto store data internally.

Parameters:
- DM_WORDS, 1024, number of 32-bit data-memory words; address index width is clog2(DM_WORDS).
- PC_RESET, 32'h00003000, reset value of W_pc.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- M_vin  in  32  value from E stage (ALU result for cal_r/cal_i, store data for cal_s, immediate for lui, pc+8 for jal)
- M_a1  in  5  rs address
- M_a2  in  5  rt address (store-data source)
- M_a3  in  5  destination register address
- M_grf_en  in  1  instruction writes GRF
- M_dm_en  in  1  instruction writes DM (store)
- M_pc  in  32  instruction PC
- M_instrbus  in  28  one-hot decode bus; bit map {cal_r[27],cal_i[26],cal_l[25],cal_s[24],cal_b[23],cal_m[22],addu,subu,ori,lw[18],sw[17],beq,lui,j,jal,jr,nop,ynew,add,sub,andx,orx,xorx,norx,addi,addiu,andi,xori[0]}
- M_aluo  in  32  ALU output; byte address for lw/sw
- M_fwd  out  32  M-stage bypass value (= M_vin, combinational) for upstream forwarding
- W_a3  out  5  registered destination address
- W_grf_en  out  1  registered GRF write enable
- W_pc  out  32  registered PC
- W_instrbus  out  28  registered instruction bus
- W_wd  out  32  registered GRF write data

Behaviour:
- Reset (async, asserted): W_a3=0, W_grf_en=0, W_pc=PC_RESET, W_instrbus=0, W_wd=0; every DM word cleared to 0. While reset is held, no DM write occurs.
- Address decode:
  - idx = M_aluo[2+:clog2(DM_WORDS)]; M_aluo[1:0] are ignored (word aligned, no exception).
  - in_range = (M_aluo[31:2] < DM_WORDS).
- Store-data forwarding: sdata = W_wd when (W_grf_en && W_a3!=0 && W_a3==M_a2), else M_vin.
- Store:
  - At posedge, if M_dm_en && sw && in_range, DM[idx] <= sdata.
  - M_dm_en without sw, or out of range: no write.
- Load read is combinational: rdata = in_range ? DM[idx] : 32'h0.
- M/W register at every posedge (no reset):
  - W_a3<=M_a3, W_grf_en<=M_grf_en, W_pc<=M_pc, W_instrbus<=M_instrbus.
  - W_wd <= (cal_l||lw) ? rdata : M_vin.
- Latency: 1 cycle M→W for all fields. A DM write is visible to a load in M the following cycle (sw at edge t, lw at t+1 reads the new data).
- Same-cycle read and write cannot occur: only one instruction occupies M.
- Bubble (instrbus=0, grf_en=0, dm_en=0) passes through unchanged; DM is untouched.
- M_a2==0 never selects forwarding; a store of $0 writes M_vin (0).
- No stall or flush inputs: the hazard unit inserts bubbles upstream.

Decomposition:
- Shared package:
  - instruction-bus bit indices (CAL_R=27 … XORI=0) and bus width 28
  - PC_RESET constant
  - DM_WORDS default
- One sub-module: dm_ram (clk, reset, we, idx, wdata, rdata), holding the DM array, its async clear, and its range check.
- The stage module keeps the forwarding mux, the load/result mux and the W registers.

Test Plan:
- Reset mid-run: store 32'hDEADBEEF to 0x0, assert reset asynchronously between edges → outputs immediately zero, W_pc=32'h3000; after release, lw 0x0 gives W_wd=0.
- sw M_aluo=0x10, M_vin=32'h12345678, then lw M_aluo=0x10 next cycle → W_wd=32'h12345678 one cycle after the lw.
- W-to-M forwarding: W_grf_en=1, W_a3=8, W_wd=32'hCAFE0001; sw with M_a2=8, M_vin=32'h0, aluo=0x20 → later lw 0x20 gives 32'hCAFE0001. Repeat with M_a2=0 → stores M_vin.
- Unaligned/out of range: sw aluo=0x13 writes word 4 (lw 0x10 reads it); sw aluo=DM_WORDS*4 → no word changes, and lw at that address gives 0.
- Non-memory pass-through: addu with M_vin=32'h7, M_a3=3, grf_en=1, pc=32'h3008 → W_wd=7, W_a3=3, W_pc=32'h3008 next cycle; jal with M_vin=32'h3010 → W_wd=32'h3010.
- Bubble: all-zero inputs for 3 cycles → W_grf_en=0, W_instrbus=0, DM contents unchanged (checked by later loads).
